// File: rtl/bsg_fpu_pkg.sv
// Shared FPU constants: default integer result width and fflags bit positions.
package bsg_fpu_pkg;

  localparam int unsigned fpu_width_gp     = 32;
  localparam int unsigned fflags_width_gp  = 5;
  localparam int unsigned fflags_nv_bit_gp = 4;

endpackage

// File: rtl/bsg_fpu_cvt_retire_if.sv
// Result handshake between the f2i stage, the retire buffer and the consumer.
interface bsg_fpu_cvt_retire_if
  import bsg_fpu_pkg::*;
#(
  parameter int unsigned width_p = fpu_width_gp
);

  logic               v_i;
  logic [width_p-1:0] z_i;
  logic               invalid_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] z_o;
  logic               invalid_o;
  logic               yumi_i;

  modport master (
    output v_i, z_i, invalid_i, yumi_i,
    input  ready_o, v_o, z_o, invalid_o
  );

  modport slave (
    input  v_i, z_i, invalid_i, yumi_i,
    output ready_o, v_o, z_o, invalid_o
  );

endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with 1-bit pointers; ready depends only on held state.
module bsg_two_fifo #(
  parameter int unsigned width_p = 33
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               rd_ptr_q;
  logic               wr_ptr_q;
  logic               full_q;
  logic               empty;
  logic               enq;
  logic               deq;

  // Equal pointers mean empty unless full_q says they wrapped onto each other.
  assign empty   = (rd_ptr_q == wr_ptr_q) && !full_q;
  assign ready_o = !full_q;
  assign v_o     = !empty;
  assign enq     = v_i && ready_o;
  assign deq     = yumi_i && v_o;
  assign data_o  = v_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= ~wr_ptr_q;
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      if (enq != deq) full_q <= enq && (wr_ptr_q != rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_fpu_cvt_retire.sv
// Retire buffer for f2i results: 2-entry FIFO plus sticky NV flag and saturating NV counter.
module bsg_fpu_cvt_retire
  import bsg_fpu_pkg::*;
#(
  parameter int unsigned width_p     = fpu_width_gp,
  parameter int unsigned cnt_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bsg_fpu_cvt_retire_if.slave    bus,
  input  logic                   clear_flags_i,
  output logic                   nv_sticky_o,
  output logic [cnt_width_p-1:0] nv_count_o
);

  logic [width_p:0]       fifo_data;
  logic                   retire_nv;
  logic                   nv_sticky_q, nv_sticky_d;
  logic [cnt_width_p-1:0] nv_count_q, nv_count_d;

  bsg_two_fifo #(
    .width_p (width_p + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (bus.v_i),
    .data_i  ({bus.invalid_i, bus.z_i}),
    .ready_o (bus.ready_o),
    .v_o     (bus.v_o),
    .data_o  (fifo_data),
    .yumi_i  (bus.yumi_i)
  );

  assign bus.z_o       = fifo_data[width_p-1:0];
  assign bus.invalid_o = fifo_data[width_p];

  assign retire_nv = bus.v_o && bus.yumi_i && bus.invalid_o;

  // A retiring invalid entry beats a same-cycle clear, restarting the count at 1.
  always_comb begin
    nv_sticky_d = nv_sticky_q;
    nv_count_d  = nv_count_q;
    if (retire_nv) begin
      nv_sticky_d = 1'b1;
      if (clear_flags_i) begin
        nv_count_d = cnt_width_p'(1);
      end else if (nv_count_q != '1) begin
        nv_count_d = nv_count_q + cnt_width_p'(1);
      end
    end else if (clear_flags_i) begin
      nv_sticky_d = 1'b0;
      nv_count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      nv_sticky_q <= 1'b0;
      nv_count_q  <= '0;
    end else begin
      nv_sticky_q <= nv_sticky_d;
      nv_count_q  <= nv_count_d;
    end
  end

  assign nv_sticky_o = nv_sticky_q;
  assign nv_count_o  = nv_count_q;

endmodule

// File: tb/tb_bsg_fpu_cvt_retire.sv
// Directed bench for bsg_fpu_cvt_retire with a queue-based reference model.
module tb_bsg_fpu_cvt_retire;
  import bsg_fpu_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned C    = 8;
  localparam int          CMAX = (1 << C) - 1;

  typedef struct {
    logic         inv;
    logic [W-1:0] z;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear_flags;
  logic         nv_sticky;
  logic [C-1:0] nv_count;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  ent_t mq[$];
  bit   m_sticky;
  int   m_count;

  bsg_fpu_cvt_retire_if #(.width_p(W)) bus ();

  bsg_fpu_cvt_retire #(
    .width_p     (W),
    .cnt_width_p (C)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .bus           (bus),
    .clear_flags_i (clear_flags),
    .nv_sticky_o   (nv_sticky),
    .nv_count_o    (nv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of pending results, flags from retirement events.
  always @(posedge clk) begin
    bit   room;
    bit   deq;
    bit   ret_nv;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_sticky = 1'b0;
      m_count  = 0;
    end else begin
      room   = (mq.size() < 2);
      deq    = bus.yumi_i && (mq.size() > 0);
      ret_nv = 1'b0;
      if (deq) begin
        ret_nv = mq[0].inv;
        void'(mq.pop_front());
      end
      if (bus.v_i && room) begin
        e.inv = bus.invalid_i;
        e.z   = bus.z_i;
        mq.push_back(e);
      end
      if (ret_nv) begin
        m_sticky = 1'b1;
        if (clear_flags)        m_count = 1;
        else if (m_count < CMAX) m_count = m_count + 1;
      end else if (clear_flags) begin
        m_sticky = 1'b0;
        m_count  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("v_o",         64'(bus.v_o),       64'(mq.size() > 0));
      chk("ready_o",     64'(bus.ready_o),   64'(mq.size() < 2));
      chk("z_o",         64'(bus.z_o),       (mq.size() > 0) ? 64'(mq[0].z) : 64'h0);
      chk("invalid_o",   64'(bus.invalid_o), (mq.size() > 0) ? 64'(mq[0].inv) : 64'h0);
      chk("nv_sticky_o", 64'(nv_sticky),     64'(m_sticky));
      chk("nv_count_o",  64'(nv_count),      64'(m_count));
    end
  end

  task automatic tick(input bit v, input logic [W-1:0] z, input bit inv, input bit yumi,
                      input bit clr);
    bus.v_i       = v;
    bus.z_i       = z;
    bus.invalid_i = inv;
    bus.yumi_i    = yumi;
    clear_flags   = clr;
    @(negedge clk);
  endtask

  initial begin
    bus.v_i       = 1'b0;
    bus.z_i       = '0;
    bus.invalid_i = 1'b0;
    bus.yumi_i    = 1'b0;
    clear_flags   = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    reset    = 1'b0;
    checking = 1'b1;

    // Reset state
    chk("rst_v_o",     64'(bus.v_o),     64'h0);
    chk("rst_z_o",     64'(bus.z_o),     64'h0);
    chk("rst_ready_o", 64'(bus.ready_o), 64'h1);
    chk("rst_sticky",  64'(nv_sticky),   64'h0);
    chk("rst_count",   64'(nv_count),    64'h0);

    // Single enqueue: visible one cycle later
    tick(1, 32'h0000_0007, 0, 0, 0);
    chk("lat_v_o",    64'(bus.v_o),   64'h1);
    chk("lat_z_o",    64'(bus.z_o),   64'h7);
    chk("lat_sticky", 64'(nv_sticky), 64'h0);
    tick(0, 0, 0, 1, 0);
    chk("drain_v_o", 64'(bus.v_o), 64'h0);
    chk("drain_z_o", 64'(bus.z_o), 64'h0);

    // Three back-to-back enqueues: third is refused
    tick(1, 32'hA, 0, 0, 0);
    chk("one_ready", 64'(bus.ready_o), 64'h1);
    tick(1, 32'hB, 0, 0, 0);
    chk("full_ready", 64'(bus.ready_o), 64'h0);
    tick(1, 32'hC, 0, 0, 0);
    chk("full_hold_ready", 64'(bus.ready_o), 64'h0);
    chk("order_first", 64'(bus.z_o), 64'hA);
    tick(0, 0, 0, 1, 0);
    chk("order_second", 64'(bus.z_o), 64'hB);
    tick(0, 0, 0, 1, 0);
    chk("third_dropped", 64'(bus.v_o), 64'h0);

    // Same-cycle enq/deq with one held leaves only the new entry
    tick(1, 32'h11, 0, 0, 0);
    tick(1, 32'h22, 0, 1, 0);
    chk("swap_z_o",   64'(bus.z_o),     64'h22);
    chk("swap_ready", 64'(bus.ready_o), 64'h1);
    tick(0, 0, 0, 1, 0);

    // Invalid retirement sets the flags; enqueue alone does not
    tick(1, 32'h7FFF_FFFF, 1, 0, 0);
    chk("enq_nv_sticky", 64'(nv_sticky),     64'h0);
    chk("enq_nv_inv",    64'(bus.invalid_o), 64'h1);
    tick(0, 0, 0, 1, 0);
    chk("ret_nv_sticky", 64'(nv_sticky), 64'h1);
    chk("ret_nv_count",  64'(nv_count),  64'h1);
    tick(1, 32'h5, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("enq_only_count", 64'(nv_count), 64'h1);
    tick(0, 0, 0, 1, 0);
    chk("second_ret_count", 64'(nv_count), 64'h2);

    // Saturation after 300 invalid retirements, then clear
    for (int i = 0; i < 300; i++) begin
      tick(1, W'(i), 1, 0, 0);
      tick(0, 0, 0, 1, 0);
    end
    chk("sat_count",  64'(nv_count),  64'd255);
    chk("sat_sticky", 64'(nv_sticky), 64'h1);
    tick(0, 0, 0, 0, 1);
    chk("clr_count",  64'(nv_count),  64'h0);
    chk("clr_sticky", 64'(nv_sticky), 64'h0);

    // Clear colliding with an invalid retirement at count 5
    for (int i = 0; i < 5; i++) begin
      tick(1, W'(i + 100), 1, 0, 0);
      tick(0, 0, 0, 1, 0);
    end
    chk("five_count", 64'(nv_count), 64'h5);
    tick(1, 32'h55, 1, 0, 0);
    tick(0, 0, 0, 1, 1);
    chk("race_count",  64'(nv_count),  64'h1);
    chk("race_sticky", 64'(nv_sticky), 64'h1);

    // Reset with two entries held; v_i during reset dropped
    tick(1, 32'h1, 1, 0, 0);
    tick(1, 32'h2, 1, 0, 0);
    chk("pre_rst_ready", 64'(bus.ready_o), 64'h0);
    reset = 1'b1;
    tick(1, 32'h3, 0, 0, 0);
    reset = 1'b0;
    chk("mid_rst_v_o",   64'(bus.v_o),     64'h0);
    chk("mid_rst_ready", 64'(bus.ready_o), 64'h1);
    chk("mid_rst_count", 64'(nv_count),    64'h0);
    chk("mid_rst_stk",   64'(nv_sticky),   64'h0);
    tick(0, 0, 1, 1, 0);
    chk("idle_yumi_v_o",   64'(bus.v_o),     64'h0);
    chk("idle_yumi_count", 64'(nv_count),    64'h0);
    chk("idle_yumi_ready", 64'(bus.ready_o), 64'h1);
    tick(1, 32'h9, 0, 0, 0);
    chk("post_rst_z_o", 64'(bus.z_o), 64'h9);
    tick(0, 0, 0, 1, 0);

    // Mixed traffic checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_fpu_cvt_retire.md
BSG_FPU_CVT_RETIRE -- requirements
Module: bsg_fpu_cvt_retire

Interface
REQ-001 Parameter width_p, default 32, SHALL set the integer result width.
REQ-002 Parameter cnt_width_p, default 8, SHALL set the invalid-event counter width.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 v_i  input  1  SHALL mark a valid conversion result from the f2i stage.
REQ-006 z_i  input  width_p  SHALL carry the converted integer.
REQ-007 invalid_i  input  1  SHALL carry that conversion's invalid (NV) flag.
REQ-008 ready_o  output  1  SHALL indicate that an input is accepted this cycle.
REQ-009 v_o  output  1  SHALL mark a valid retiring result.
REQ-010 z_o  output  width_p  SHALL carry the head result.
REQ-011 invalid_o  output  1  SHALL carry the head entry's NV flag.
REQ-012 yumi_i  input  1  SHALL be the consumer's dequeue of the head; legal only when v_o=1.
REQ-013 clear_flags_i  input  1  SHALL clear the sticky flag and the counter.
REQ-014 nv_sticky_o  output  1  SHALL be the accumulated NV flag (fflags.NV).
REQ-015 nv_count_o  output  cnt_width_p  SHALL be the saturating count of retired invalid results.

Function
REQ-016 The block SHALL buffer results in a 2-entry FIFO; enqueue occurs on v_i & ready_o, dequeue on yumi_i.
REQ-017 ready_o SHALL be 1 iff fewer than 2 entries are held; it SHALL NOT depend combinationally on yumi_i.
REQ-018 If the FIFO is full, then ready_o=0, so a same-cycle yumi_i frees a slot only from the next cycle.
REQ-019 v_o SHALL be 1 iff at least 1 entry is held; latency from enqueue into an empty FIFO to v_o=1 SHALL be exactly 1 cycle.
REQ-020 Order SHALL be preserved; enqueue and dequeue in the same cycle with 1 entry held SHALL leave 1 entry, the new one.
REQ-021 z_o and invalid_o SHALL be driven to 0 while v_o=0.
REQ-022 The FIFO SHALL use 1-bit read and write pointers that wrap 1->0, plus a full/empty bit for disambiguation.
REQ-023 nv_sticky_o SHALL be set in the cycle after the retirement (v_o & yumi_i) of an entry with invalid_o=1.
REQ-024 nv_sticky_o SHALL otherwise hold, and SHALL clear the cycle after clear_flags_i=1.
REQ-025 If clear_flags_i coincides with retirement of an invalid entry, the set SHALL win: nv_sticky_o=1 and nv_count_o=1.
REQ-026 nv_count_o SHALL increment by 1 per retired invalid entry and saturate at 2^cnt_width_p-1 (255 by default), never wrapping.
REQ-027 Enqueue of an invalid entry SHALL NOT affect the flags; only retirement counts.
REQ-028 yumi_i while v_o=0 SHALL be ignored; no state changes and no count.

Reset
REQ-029 While reset_i=1 at a clock edge, the FIFO SHALL become empty and the sticky flag and counter SHALL become 0.
REQ-030 After reset: v_o=0, z_o=0, invalid_o=0, nv_sticky_o=0, nv_count_o=0, ready_o=1.
REQ-031 Reset mid-operation SHALL discard buffered entries without counting them; v_i during reset SHALL be dropped.

Structure
REQ-032 Shared package bsg_fpu_pkg SHALL hold the result width default (32) and the NV flag bit index of the fflags vector.
REQ-033 Buffering SHALL be a sub-module instance of bsg_two_fifo (width width_p+1, payload {invalid, z}).
REQ-034 Flag accumulation and counter SHALL be local logic in bsg_fpu_cvt_retire.

Verification
REQ-035 Reset, then v_i=1, z_i=32'h0000_0007, invalid_i=0, yumi_i=0 -> next cycle v_o=1, z_o=7; nv_sticky_o=0.
REQ-036 Enqueue 3 back-to-back with yumi_i=0 -> ready_o=0 after the 2nd; the 3rd is not accepted; retire gives the first 2 in order.
REQ-037 Retire z=32'h7FFF_FFFF with invalid=1 -> next cycle nv_sticky_o=1, nv_count_o=1; enqueue only (no yumi) -> count unchanged.
REQ-038 Retire 300 invalid results -> nv_count_o=255 thereafter; clear_flags_i pulse -> 0 and 0.
REQ-039 clear_flags_i concurrent with an invalid retirement, count=5 -> nv_count_o=1, nv_sticky_o=1.
REQ-040 With 2 entries held, assert reset_i -> v_o=0, ready_o=1, counters 0; yumi_i with v_o=0 is ignored.
